// File: rtl/alu_pkg.sv
// Shared definitions for alu_seq: opcodes, FSM states, flag bundle and parity helper.
// The MUL state exists only when ALU_MUL_EN is defined.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOR   = 4'h5;
  localparam logic [3:0] OP_SLL   = 4'h6;
  localparam logic [3:0] OP_SRL   = 4'h7;
  localparam logic [3:0] OP_SRA   = 4'h8;
  localparam logic [3:0] OP_ROL   = 4'h9;
  localparam logic [3:0] OP_SLT   = 4'hA;
  localparam logic [3:0] OP_SLTU  = 4'hB;
  localparam logic [3:0] OP_MUL   = 4'hC;
  localparam logic [3:0] OP_MULHU = 4'hD;

  // Widest result the parity helper handles; narrower values are zero-extended.
  localparam int unsigned PF_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD
`ifdef ALU_MUL_EN
    ,
    ST_MUL
`endif
  } alu_state_t;

  typedef struct packed {
    logic zf;
    logic cf;
    logic of;
    logic sf;
    logic pf;
  } alu_flags_t;

  // Even parity: 1 when the number of set bits is even.
  function automatic logic calc_pf(input logic [PF_W-1:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one bit of b per cycle, 2*WIDTH-bit product.
// The first partial product is folded into the start cycle so done rises
// WIDTH-1 cycles after start. Used by alu_seq only when ALU_MUL_EN is defined.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  // One shift-add step: upper half accumulates mcand when the current multiplier LSB is set.
  function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                              input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    return {sum, p[WIDTH-1:1]};
  endfunction

  // Accumulator, multiplicand and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      mcand_q <= a;
      acc_q   <= step({{WIDTH{1'b0}}, b}, a);
      cnt_q   <= CW'(1);
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q == CW'(WIDTH)) begin
        busy_q <= 1'b0;
      end else begin
        acc_q <= step(acc_q, mcand_q);
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CW'(WIDTH));
  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: valid/ready in, registered result and flags out.
// Define ALU_MUL_EN to enable the iterative MUL/MULHU path; otherwise those opcodes are illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zf,
  output logic             cf,
  output logic             of,
  output logic             sf,
  output logic             pf,
  output logic             err
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_state_t       state, state_next;
  logic             accept;
  logic             load_alu;

  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] res;
  alu_flags_t       res_flags;
  logic             res_err;

  logic [WIDTH-1:0] f_q;
  alu_flags_t       flags_q;
  logic             err_q;

`ifdef ALU_MUL_EN
  logic               is_mul_op;
  logic               start_mul;
  logic               mul_busy, mul_done, mul_fin;
  logic [2*WIDTH-1:0] prod;
  logic               mul_hi_q;
  logic [WIDTH-1:0]   mul_res;
  alu_flags_t         mul_flags;

  assign is_mul_op = (op == OP_MUL) || (op == OP_MULHU);
  assign start_mul = accept && is_mul_op;
  assign load_alu  = accept && !is_mul_op;
  assign mul_fin   = (state == ST_MUL) && mul_busy && mul_done;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_mul),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (prod)
  );

  // Remember at accept whether the high or low product half is wanted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         mul_hi_q <= 1'b0;
    else if (start_mul) mul_hi_q <= (op == OP_MULHU);
  end

  // Select product half and derive its flags.
  always_comb begin
    mul_res      = mul_hi_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    mul_flags    = '0;
    mul_flags.zf = (mul_res == '0);
    mul_flags.sf = mul_res[WIDTH-1];
    mul_flags.pf = calc_pf(PF_W'(mul_res));
    mul_flags.cf = (prod[2*WIDTH-1:WIDTH] != '0);
    mul_flags.of = (prod[2*WIDTH-1:WIDTH] != '0);
  end
`else
  assign load_alu = accept;
`endif

  assign sh    = b[SHW-1:0];
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};

  // Single-cycle datapath and flags; unknown opcodes give f=0 with err set.
  always_comb begin
    res       = '0;
    res_err   = 1'b0;
    res_flags = '0;
    case (op)
      OP_ADD: begin
        res          = add_w[WIDTH-1:0];
        res_flags.cf = add_w[WIDTH];
        res_flags.of = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res          = sub_w[WIDTH-1:0];
        res_flags.cf = sub_w[WIDTH];
        res_flags.of = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      OP_SLL:  res = a << sh;
      OP_SRL:  res = a >> sh;
      OP_SRA:  res = $signed(a) >>> sh;
      OP_ROL:  res = (a << sh) | (a >> (WIDTH - 32'(sh)));
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: res_err = 1'b1;
    endcase
    res_flags.zf = (res == '0);
    res_flags.sf = res[WIDTH-1];
    res_flags.pf = calc_pf(PF_W'(res));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Handshake and next-state logic; HOLD with out_ready behaves like IDLE for accepts.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_HOLD: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid && in_ready;
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          state_next = is_mul_op ? ST_MUL : ST_HOLD;
`else
          state_next = ST_HOLD;
`endif
        end else if (state == ST_HOLD && out_ready) begin
          state_next = ST_IDLE;
        end
      end
`ifdef ALU_MUL_EN
      ST_MUL: if (mul_fin) state_next = ST_HOLD;
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Output register: loads on single-cycle accept or multiplier completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q     <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else if (load_alu) begin
      f_q     <= res;
      flags_q <= res_flags;
      err_q   <= res_err;
`ifdef ALU_MUL_EN
    end else if (mul_fin) begin
      f_q     <= mul_res;
      flags_q <= mul_flags;
      err_q   <= 1'b0;
`endif
    end
  end

  assign out_valid            = (state == ST_HOLD);
  assign f                    = f_q;
  assign {zf, cf, of, sf, pf} = flags_q;
  assign err                  = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq; expectations follow ALU_MUL_EN when defined.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] f;
  logic             zf, cf, of, sf, pf, err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [37:0] exp_q[$];
  string       name_q[$];

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .zf        (zf),
    .cf        (cf),
    .of        (of),
    .sf        (sf),
    .pf        (pf),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] mk(input logic [31:0] fv, input logic z, input logic c,
                                     input logic o, input logic s, input logic p, input logic e);
    return {fv, z, c, o, s, p, e};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  // Monitor: pops one expectation per output handshake.
  initial begin
    logic [37:0] e, act;
    string       nm;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        act = {f, zf, cf, of, sf, pf, err};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got f=%h zcosp=%b err=%b with nothing expected",
                   f, act[5:1], err);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got f=%h zcosp=%b err=%b, expected f=%h zcosp=%b err=%b",
                     nm, act[37:6], act[5:1], act[0], e[37:6], e[5:1], e[0]);
          end
        end
      end
    end
  end

  // Issue one op, push its expectation at accept, then check latency (and in_ready low while busy).
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [37:0] e, input int lat, input string nm);
    int n;
    logic rdy_seen;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        check({nm, "_accept_timeout"}, 64'(in_ready), 64'(1));
        break;
      end
    end
    @(posedge clk);
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1;
    in_valid = 1'b0; op = OP_SUB; a = ~x; b = ~y;
    n = 0;
    rdy_seen = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      if (out_valid || n >= 100) break;
      if (in_ready) rdy_seen = 1'b1;
    end
    check({nm, "_latency"}, 64'(n), 64'(lat));
    if (lat > 1) check({nm, "_in_ready_low"}, 64'(rdy_seen), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [37:0] snap;
    logic        stale;
    in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_outputs", 64'({f, zf, cf, of, sf, pf, err}), 64'(0));

    run_op(OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, 0,0,1,1,0, 0), 1, "add_ovf");
    run_op(OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0000_0000, 1,1,0,0,1, 0), 1, "add_carry");
    run_op(OP_SUB,  32'h0000_0000, 32'h0000_0001, mk(32'hFFFF_FFFF, 0,1,0,1,1, 0), 1, "sub_borrow");
    run_op(OP_SUB,  32'h8000_0000, 32'h0000_0001, mk(32'h7FFF_FFFF, 0,0,1,0,0, 0), 1, "sub_ovf");
    run_op(OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, mk(32'h00F0_00F0, 0,0,0,0,1, 0), 1, "and");
    run_op(OP_OR,   32'h0000_0000, 32'h0000_0000, mk(32'h0000_0000, 1,0,0,0,1, 0), 1, "or_zero");
    run_op(OP_XOR,  32'hA5A5_A5A5, 32'hFFFF_FFFF, mk(32'h5A5A_5A5A, 0,0,0,0,1, 0), 1, "xor");
    run_op(OP_NOR,  32'h0000_0000, 32'h0000_0000, mk(32'hFFFF_FFFF, 0,0,0,1,1, 0), 1, "nor");
    run_op(OP_SLL,  32'h0000_0001, 32'h0000_001F, mk(32'h8000_0000, 0,0,0,1,0, 0), 1, "sll31");
    run_op(OP_SRL,  32'h8000_0000, 32'h0000_0021, mk(32'h4000_0000, 0,0,0,0,0, 0), 1, "srl_masked");
    run_op(OP_SRA,  32'h8000_0000, 32'h0000_0024, mk(32'hF800_0000, 0,0,0,1,0, 0), 1, "sra");
    run_op(OP_ROL,  32'h8000_0001, 32'h0000_0004, mk(32'h0000_0018, 0,0,0,0,1, 0), 1, "rol");
    run_op(OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0000_0001, 0,0,0,0,0, 0), 1, "slt");
    run_op(OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0000_0000, 1,0,0,0,1, 0), 1, "sltu");
    run_op(4'hF,    32'h1234_5678, 32'h9ABC_DEF0, mk(32'h0000_0000, 1,0,0,0,1, 1), 1, "illegal_f");
`ifdef ALU_MUL_EN
    run_op(OP_MUL,   32'h0000_FFFF, 32'h0000_FFFF, mk(32'hFFFE_0001, 0,0,0,1,1, 0), WIDTH, "mul");
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'h0000_0002, mk(32'h0000_0001, 0,1,1,0,0, 0), WIDTH, "mulhu");
`else
    run_op(OP_MUL,   32'h0000_FFFF, 32'h0000_FFFF, mk(32'h0000_0000, 1,0,0,0,1, 1), 1, "mul_disabled");
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'h0000_0002, mk(32'h0000_0000, 1,0,0,0,1, 1), 1, "mulhu_disabled");
`endif

    // Backpressure: ADD result held three cycles while an XOR waits at the input.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; op = OP_ADD; a = 32'h1234_0000; b = 32'h0000_5678;
    @(posedge clk);
    exp_q.push_back(mk(32'h1234_5678, 0,0,0,0,0, 0));
    name_q.push_back("bp_add");
    #1 op = OP_XOR; a = 32'hFF00_FF00; b = 32'h0F0F_0F0F;
    @(negedge clk);
    check("bp_add_valid", 64'(out_valid), 64'(1));
    snap = {f, zf, cf, of, sf, pf, err};
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_stable", 64'({f, zf, cf, of, sf, pf, err}), 64'(snap));
      check("bp_in_ready_low", 64'(in_ready), 64'(0));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_release", 64'(in_ready), 64'(1));
    @(posedge clk);
    exp_q.push_back(mk(32'hF00F_F00F, 0,0,0,1,1, 0));
    name_q.push_back("bp_xor");
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_xor_latency", 64'(out_valid), 64'(1));

    // Asynchronous reset while busy: result must vanish and never reappear.
    @(posedge clk); #1;
`ifdef ALU_MUL_EN
    in_valid = 1'b1; op = OP_MUL; a = 32'h0000_1234; b = 32'h0000_5678;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
`else
    out_ready = 1'b0; in_valid = 1'b1; op = OP_ADD; a = 32'h0000_0003; b = 32'h0000_0004;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_outputs", 64'({f, zf, cf, of, sf, pf, err}), 64'(0));
    #3 rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    stale = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("rst_no_stale_result", 64'(stale), 64'(0));

    run_op(OP_ADD, 32'h0000_0003, 32'h0000_0004, mk(32'h0000_0007, 0,0,0,0,0, 0), 1, "post_rst_add");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle combinational ALU. It accepts an operation on a valid/ready input channel and returns a registered result plus flags on a valid/ready output channel. Single-cycle ops sustain one result per clock. An optional iterative multiplier runs over WIDTH cycles. It sits between the decode/issue stage and writeback of the lab CPU datapath.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥8
- SHW, $clog2(WIDTH), shift-amount bits taken from B (derived, not overridden)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept this cycle
- op  in  4  opcode
- a, b  in  WIDTH  operands
- out_valid  out  1  result held in output register
- out_ready  in  1  consumer takes result this cycle
- f  out  WIDTH  result
- zf, cf, of, sf, pf  out  1  flags, valid with out_valid
- err  out  1  illegal/disabled opcode, valid with out_valid

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLL, 7 SRL, 8 SRA, 9 ROL (shifts/rotate by b[SHW-1:0])
  - A SLT (signed), B SLTU (result 0 or 1)
  - C MUL (low WIDTH bits), D MULHU (high WIDTH bits, unsigned)
  - E, F illegal
- Flags:
  - zf = (f==0); sf = f[WIDTH-1]; pf = even number of ones in f.
  - ADD: cf = carry out; of = signed overflow (a,b same sign, f sign differs).
  - SUB: cf = borrow (a<b unsigned); of = a,b differ in sign and f sign ≠ a sign.
  - MUL/MULHU: cf = of = (high half of the 2·WIDTH product ≠ 0).
  - All other ops: cf = of = 0.
- Illegal opcode: f=0, err=1, flags computed on f=0 (zf=1, pf=1), single-cycle latency.
- FSM states:
  - IDLE: output register empty.
  - HOLD: result valid, waiting for out_ready.
  - MUL: iterating.
- Transitions:
  - IDLE + accept of single-cycle op → HOLD.
  - IDLE + accept of MUL/MULHU → MUL.
  - MUL after WIDTH iterations → HOLD.
  - HOLD + out_ready, with no accept → IDLE.
  - HOLD + out_ready, with accept → HOLD (single-cycle op) or MUL (multiply op).
- in_ready = (state==IDLE) || (state==HOLD && out_ready). It is never high in MUL.
- Multiplier: unsigned shift-add, one bit of b per cycle, 2·WIDTH-bit accumulator; op latched at accept selects low/high half.

## Timing
- Reset values: out_valid=0, f=0, all flags 0, err=0, state=IDLE, so in_ready=1 once rst_n is high.
- Single-cycle op accepted at edge T: out_valid=1 from T+1. Back-to-back throughput is 1/cycle while out_ready=1.
- MUL/MULHU accepted at T: out_valid=1 from T+WIDTH. in_ready=0 for cycles T+1 … T+WIDTH-1.
- Backpressure: while out_valid && !out_ready, f/flags/err are held stable and nothing is accepted.
- Operands are sampled only at accept; later changes on a/b/op are ignored.
- Async reset mid-MUL or mid-HOLD: result is discarded, outputs go to reset values immediately, and no stale out_valid appears after release.

## Configuration
- ALU_MUL_EN defined: opcodes C/D are executed by the iterative multiplier as above.
- ALU_MUL_EN undefined:
  - Multiplier logic and the MUL state are removed.
  - C/D are treated as illegal: f=0, err=1, latency 1.
  - in_ready reduces to !out_valid || out_ready.

## Structure
- Shared package alu_pkg:
  - opcode localparams (OP_ADD … OP_MULHU)
  - FSM state enum
  - packed flags struct {zf,cf,of,sf,pf}
  - function computing pf
- Sub-module alu_mul_iter (WIDTH param; start/busy/done, 2·WIDTH-bit product), instantiated only under ALU_MUL_EN.

## Test plan
- ADD a=0x7FFFFFFF b=1 → f=0x80000000, of=1 cf=0 sf=1 zf=0 pf=0, err=0, out_valid 1 cycle after accept.
- SUB a=0 b=1 → f=0xFFFFFFFF, cf=1 of=0 sf=1 pf=1. SRA a=0x80000000 b=0x24 → f=0xF8000000.
- MUL a=0xFFFF b=0xFFFF → f=0xFFFE0001, cf=of=0, out_valid exactly 32 cycles after accept, in_ready low meanwhile. MULHU 0xFFFFFFFF×2 → f=1, cf=of=1.
- Hold out_ready=0 for 3 cycles after ADD result → f/flags stable, in_ready=0. On out_ready=1 with a queued XOR, accept occurs in the same cycle and XOR's out_valid follows next cycle.
- Pulse rst_n low at cycle 10 of a MUL → out_valid=0 immediately, in_ready=1 after release, no result appears.
- op=0xF (and op=0xC with ALU_MUL_EN undefined) → f=0, err=1, zf=1, latency 1.
